// File: rtl/vga_snapshot_ctrl.sv
// Frame-synchronous debug snapshot: latches the live debug bus into a shadow register at
// vsync start, with freeze and single-frame step for on-screen debugging.
module vga_snapshot_ctrl #(
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned FRAME_DIV  = 1,
    parameter int unsigned VS_ACT_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vs,
    input  logic [DATA_W-1:0] dbg_in,
    input  logic              freeze,
    input  logic              step_req,
    output logic              step_ack,
    output logic [DATA_W-1:0] snap_out,
    output logic              snap_valid,
    output logic [15:0]       frame_cnt
);

    localparam logic       VS_IDLE  = 1'(VS_ACT_LOW);
    localparam logic       VS_ACT   = ~VS_IDLE;
    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FROZEN    = 2'd1,
        ST_STEP_WAIT = 2'd2
    } state_t;

    state_t            state_q;
    logic              vs_q;
    logic              step_q;
    logic              step_ack_q;
    logic              snap_valid_q;
    logic [7:0]        div_q;
    logic [DATA_W-1:0] snap_q;
    logic [15:0]       frame_cnt_q;

    logic vs_start_c;
    logic step_edge_c;
    logic capture_c;

    // A capture happens on a divided vsync in RUN, or on any vsync while a step is pending.
    always_comb begin
        vs_start_c  = (vs == VS_ACT) && (vs_q != VS_ACT);
        step_edge_c = step_req && !step_q;
        capture_c   = 1'b0;
        if (vs_start_c) begin
            if (state_q == ST_RUN && !freeze && div_q == DIV_LAST) begin
                capture_c = 1'b1;
            end
            if (state_q == ST_STEP_WAIT) begin
                capture_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            vs_q         <= VS_IDLE;
            step_q       <= 1'b0;
            step_ack_q   <= 1'b0;
            snap_valid_q <= 1'b0;
            div_q        <= 8'd0;
            snap_q       <= '0;
            frame_cnt_q  <= 16'd0;
        end else begin
            vs_q        <= vs;
            step_q      <= step_req;
            step_ack_q  <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'(vs_start_c);

            if (capture_c) begin
                snap_q       <= dbg_in;
                snap_valid_q <= 1'b1;
            end

            unique case (state_q)
                ST_RUN: begin
                    if (freeze) begin
                        state_q <= ST_FROZEN;
                        div_q   <= 8'd0;
                    end else if (vs_start_c) begin
                        div_q <= (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
                    end
                end
                ST_FROZEN: begin
                    // Dropping freeze wins over a coincident step request.
                    if (!freeze) begin
                        state_q <= ST_RUN;
                    end else if (step_edge_c) begin
                        state_q <= ST_STEP_WAIT;
                    end
                end
                ST_STEP_WAIT: begin
                    if (vs_start_c) begin
                        step_ack_q <= 1'b1;
                        state_q    <= freeze ? ST_FROZEN : ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    div_q   <= 8'd0;
                end
            endcase
        end
    end

    assign step_ack   = step_ack_q;
    assign snap_out   = snap_q;
    assign snap_valid = snap_valid_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_snapshot_ctrl.sv
// Directed bench for vga_snapshot_ctrl: per-cycle vector table on a FRAME_DIV=1 instance,
// plus hand sequences for async reset, FRAME_DIV=2 decimation and frame counter wrap.
module tb_vga_snapshot_ctrl;

    localparam int unsigned DW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          vs;
    logic          freeze;
    logic          step_req;
    logic [DW-1:0] dbg;

    logic          u1_ack, u1_valid, u2_ack, u2_valid;
    logic [DW-1:0] u1_snap, u2_snap;
    logic [15:0]   u1_fcnt, u2_fcnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_snapshot_ctrl #(.DATA_W(DW), .FRAME_DIV(1), .VS_ACT_LOW(1)) u_div1 (
        .clk(clk), .rst(rst), .vs(vs), .dbg_in(dbg), .freeze(freeze), .step_req(step_req),
        .step_ack(u1_ack), .snap_out(u1_snap), .snap_valid(u1_valid), .frame_cnt(u1_fcnt)
    );

    vga_snapshot_ctrl #(.DATA_W(DW), .FRAME_DIV(2), .VS_ACT_LOW(1)) u_div2 (
        .clk(clk), .rst(rst), .vs(vs), .dbg_in(dbg), .freeze(freeze), .step_req(step_req),
        .step_ack(u2_ack), .snap_out(u2_snap), .snap_valid(u2_valid), .frame_cnt(u2_fcnt)
    );

    typedef struct {
        logic        vs;
        logic        frz;
        logic        stp;
        logic [7:0]  dbg;
        logic [7:0]  snap;
        logic        valid;
        logic        ack;
        logic [15:0] fcnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic f, logic s, logic [7:0] d,
                                logic [7:0] sn, logic va, logic ak, logic [15:0] fc);
        vec_t r;
        r.vs = v; r.frz = f; r.stp = s; r.dbg = d;
        r.snap = sn; r.valid = va; r.ack = ak; r.fcnt = fc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " u1 snap"},  u1_snap, '0);
        chk({tag, " u1 valid"}, DW'(u1_valid), '0);
        chk({tag, " u1 ack"},   DW'(u1_ack), '0);
        chk({tag, " u1 fcnt"},  DW'(u1_fcnt), '0);
        chk({tag, " u2 snap"},  u2_snap, '0);
        chk({tag, " u2 valid"}, DW'(u2_valid), '0);
        chk({tag, " u2 fcnt"},  DW'(u2_fcnt), '0);
    endtask

    initial begin
        //                 vs frz stp dbg    snap  val ack fcnt
        tbl.push_back(mk(1, 0, 0, 8'hA5, 8'h00, 0, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 8'hA5, 8'hA5, 1, 0, 16'd1));
        tbl.push_back(mk(1, 0, 0, 8'hB1, 8'hA5, 1, 0, 16'd1));
        tbl.push_back(mk(1, 1, 0, 8'hB1, 8'hA5, 1, 0, 16'd1));
        tbl.push_back(mk(0, 1, 0, 8'hB2, 8'hA5, 1, 0, 16'd2));
        tbl.push_back(mk(1, 1, 0, 8'hB3, 8'hA5, 1, 0, 16'd2));
        tbl.push_back(mk(0, 1, 0, 8'hB3, 8'hA5, 1, 0, 16'd3));
        tbl.push_back(mk(1, 1, 0, 8'hB4, 8'hA5, 1, 0, 16'd3));
        tbl.push_back(mk(0, 1, 0, 8'hB4, 8'hA5, 1, 0, 16'd4));
        tbl.push_back(mk(1, 0, 0, 8'hC7, 8'hA5, 1, 0, 16'd4));
        tbl.push_back(mk(0, 0, 0, 8'hC7, 8'hC7, 1, 0, 16'd5));
        tbl.push_back(mk(1, 0, 0, 8'hC7, 8'hC7, 1, 0, 16'd5));
        tbl.push_back(mk(0, 1, 0, 8'hD0, 8'hC7, 1, 0, 16'd6));
        tbl.push_back(mk(1, 1, 0, 8'hD0, 8'hC7, 1, 0, 16'd6));
        tbl.push_back(mk(1, 1, 1, 8'h11, 8'hC7, 1, 0, 16'd6));
        tbl.push_back(mk(0, 1, 1, 8'h11, 8'h11, 1, 1, 16'd7));
        tbl.push_back(mk(1, 1, 1, 8'h22, 8'h11, 1, 0, 16'd7));
        tbl.push_back(mk(0, 1, 1, 8'h22, 8'h11, 1, 0, 16'd8));
        tbl.push_back(mk(1, 1, 1, 8'h33, 8'h11, 1, 0, 16'd8));
        tbl.push_back(mk(0, 1, 1, 8'h33, 8'h11, 1, 0, 16'd9));
        tbl.push_back(mk(1, 1, 0, 8'h33, 8'h11, 1, 0, 16'd9));
        tbl.push_back(mk(0, 1, 1, 8'h44, 8'h11, 1, 0, 16'd10));
        tbl.push_back(mk(1, 1, 1, 8'h55, 8'h11, 1, 0, 16'd10));
        tbl.push_back(mk(0, 1, 1, 8'h55, 8'h55, 1, 1, 16'd11));
        tbl.push_back(mk(1, 0, 0, 8'h55, 8'h55, 1, 0, 16'd11));
        tbl.push_back(mk(1, 1, 0, 8'h66, 8'h55, 1, 0, 16'd11));
        tbl.push_back(mk(1, 1, 1, 8'h66, 8'h55, 1, 0, 16'd11));
        tbl.push_back(mk(1, 0, 0, 8'h66, 8'h55, 1, 0, 16'd11));
        tbl.push_back(mk(0, 0, 0, 8'h77, 8'h77, 1, 1, 16'd12));
        tbl.push_back(mk(1, 0, 0, 8'h88, 8'h77, 1, 0, 16'd12));
        tbl.push_back(mk(0, 0, 0, 8'h88, 8'h88, 1, 0, 16'd13));
        tbl.push_back(mk(1, 1, 0, 8'h88, 8'h88, 1, 0, 16'd13));
        tbl.push_back(mk(1, 0, 1, 8'h99, 8'h88, 1, 0, 16'd13));
        tbl.push_back(mk(0, 0, 0, 8'h99, 8'h99, 1, 0, 16'd14));
        tbl.push_back(mk(1, 0, 0, 8'h99, 8'h99, 1, 0, 16'd14));
        tbl.push_back(mk(1, 0, 1, 8'hAA, 8'h99, 1, 0, 16'd14));
        tbl.push_back(mk(1, 1, 1, 8'hAA, 8'h99, 1, 0, 16'd14));
        tbl.push_back(mk(0, 1, 1, 8'hAB, 8'h99, 1, 0, 16'd15));
        tbl.push_back(mk(1, 0, 0, 8'hAB, 8'h99, 1, 0, 16'd15));

        rst = 1'b1; vs = 1'b1; freeze = 1'b0; step_req = 1'b0; dbg = '0;
        #12;
        chk_all_zero("por");
        @(negedge clk);
        rst = 1'b0;

        // One posedge per vector: drive at negedge, check at the following negedge.
        foreach (tbl[i]) begin
            vs = tbl[i].vs; freeze = tbl[i].frz; step_req = tbl[i].stp; dbg = DW'(tbl[i].dbg);
            @(negedge clk);
            chk($sformatf("v%0d snap", i),  u1_snap, DW'(tbl[i].snap));
            chk($sformatf("v%0d valid", i), DW'(u1_valid), DW'(tbl[i].valid));
            chk($sformatf("v%0d ack", i),   DW'(u1_ack), DW'(tbl[i].ack));
            chk($sformatf("v%0d fcnt", i),  DW'(u1_fcnt), DW'(tbl[i].fcnt));
        end

        // Park u_div1 in STEP_WAIT, then hit it with an asynchronous mid-cycle reset.
        freeze = 1'b1; step_req = 1'b0; vs = 1'b1;
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("async rst");
        @(negedge clk);
        rst = 1'b0; freeze = 1'b0; step_req = 1'b0; vs = 1'b1; dbg = '0;
        @(negedge clk);

        // FRAME_DIV=2 decimation; vs held active two cycles to confirm a single start per pulse.
        for (int k = 1; k <= 6; k++) begin
            vs = 1'b0; dbg = DW'(k - 1);
            @(negedge clk);
            chk($sformatf("div2 f%0d snap", k), u2_snap,
                DW'((k % 2 == 0) ? k - 1 : ((k >= 2) ? k - 2 : 0)));
            chk($sformatf("div2 f%0d valid", k), DW'(u2_valid), DW'(k >= 2));
            chk($sformatf("div1 f%0d snap", k), u1_snap, DW'(k - 1));
            chk($sformatf("div1 f%0d ack", k), DW'(u1_ack), '0);
            @(negedge clk);
            chk($sformatf("div2 f%0d fcnt", k), DW'(u2_fcnt), DW'(k));
            chk($sformatf("div1 f%0d fcnt", k), DW'(u1_fcnt), DW'(k));
            vs = 1'b1;
            @(negedge clk);
        end

        // Counter wrap: preload near the top instead of running 65536 real frames.
        force u_div1.frame_cnt_q = 16'hFFFE;
        @(negedge clk);
        release u_div1.frame_cnt_q;
        @(negedge clk);
        chk("wrap preload", DW'(u1_fcnt), DW'(16'hFFFE));
        vs = 1'b0;
        @(negedge clk);
        chk("wrap ffff", DW'(u1_fcnt), DW'(16'hFFFF));
        vs = 1'b1;
        @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        chk("wrap 0000", DW'(u1_fcnt), DW'(16'h0000));
        chk("div2 fcnt after wrap", DW'(u2_fcnt), DW'(8));
        vs = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
